// File: rtl/uart_tx_wb.sv
// rtl/uart_tx_wb.sv - Wishbone classic slave, buffered 8N1 UART transmitter
module uart_tx_wb #(
    parameter int          DAT_WIDTH   = 32,
    parameter int          ADR_WIDTH   = 32,
    parameter int          SEL_WIDTH   = 4,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 utx_stb_i,
    input  logic                 utx_cyc_i,
    input  logic                 utx_we_i,
    input  logic [SEL_WIDTH-1:0] utx_sel_i,
    input  logic [ADR_WIDTH-1:0] utx_adr_i,
    input  logic [DAT_WIDTH-1:0] utx_dat_i,
    output logic [DAT_WIDTH-1:0] utx_dat_o,
    output logic                 utx_ack_o,
    output logic                 utx_err_o,
    output logic                 utx_tx_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_UNMAP  = 2'd3;

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [LVL_W-1:0] LVL_ONE = 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 pop;
    logic                 req;
    logic                 push;
    logic                 full;
    logic                 empty;
    logic                 busy;
    logic                 wr_err;
    logic [1:0]           reg_sel;
    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [15:0]          div_reg;
    logic [15:0]          div_lat;
    logic [15:0]          bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic [DAT_WIDTH-1:0] rd_data;
    logic                 unused_ok;

    assign unused_ok = ^{utx_dat_i[DAT_WIDTH-1:16], utx_adr_i[ADR_WIDTH-1:4],
                         utx_adr_i[1:0], utx_sel_i[SEL_WIDTH-1:2]};

    assign reg_sel = utx_adr_i[3:2];
    assign req     = utx_stb_i & utx_cyc_i & ~utx_ack_o & ~utx_err_o;
    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign busy    = (state != ST_IDLE);
    // A byte write to a full FIFO is refused; a same-cycle pop does not rescue it.
    assign wr_err  = utx_we_i & (reg_sel == REG_DATA) & utx_sel_i[0] & full;
    assign push    = req & utx_we_i & (reg_sel == REG_DATA) & utx_sel_i[0] & ~full;

    // Read mux, captured into dat_o in the response cycle
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_data[0]           = busy;
                rd_data[1]           = full;
                rd_data[2]           = empty;
                rd_data[8 +: LVL_W]  = level;
            end
            REG_DIV:    rd_data[15:0] = div_reg;
            default:    rd_data = '0;
        endcase
    end

    // Registered single-cycle ack/err with read data
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            utx_ack_o <= 1'b0;
            utx_err_o <= 1'b0;
            utx_dat_o <= '0;
        end else begin
            utx_ack_o <= 1'b0;
            utx_err_o <= 1'b0;
            utx_dat_o <= '0;
            if (req) begin
                if (reg_sel == REG_UNMAP || wr_err) begin
                    utx_err_o <= 1'b1;
                end else begin
                    utx_ack_o <= 1'b1;
                    if (!utx_we_i) begin
                        utx_dat_o <= rd_data;
                    end
                end
            end
        end
    end

    // Baud divisor register with byte-lane gating
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_reg <= DEFAULT_DIV;
        end else if (req && utx_we_i && reg_sel == REG_DIV) begin
            if (utx_sel_i[0]) div_reg[7:0]  <= utx_dat_i[7:0];
            if (utx_sel_i[1]) div_reg[15:8] <= utx_dat_i[15:8];
        end
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= utx_dat_i[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Transmitter state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a pop starts every frame, including a chained one from STOP
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_nxt = ST_START;
                    pop       = 1'b1;
                end
            end
            ST_START: begin
                if (bit_cnt == 16'd0) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_cnt == 16'd0 && bit_idx == 3'd7) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (bit_cnt == 16'd0) begin
                    if (!empty) begin
                        state_nxt = ST_START;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bit timing and shift register; divisor is frozen per frame in div_lat
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_lat <= DEFAULT_DIV;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (pop) begin
            shreg   <= fifo_mem[rd_ptr];
            div_lat <= div_reg;
            bit_cnt <= div_reg;
            bit_idx <= '0;
        end else if (state != ST_IDLE) begin
            if (bit_cnt == 16'd0) begin
                bit_cnt <= div_lat;
                if (state == ST_DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_cnt <= bit_cnt - 16'd1;
            end
        end
    end

    // Registered serial line driven from the current state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            utx_tx_o <= 1'b1;
        end else begin
            case (state)
                ST_START: utx_tx_o <= 1'b0;
                ST_DATA:  utx_tx_o <= shreg[0];
                default:  utx_tx_o <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_wb.sv
// tb/tb_uart_tx_wb.sv - randomized self-checking bench for uart_tx_wb
module tb_uart_tx_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        tx;

    uart_tx_wb dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .utx_stb_i (stb),
        .utx_cyc_i (cyc),
        .utx_we_i  (we),
        .utx_sel_i (sel),
        .utx_adr_i (adr),
        .utx_dat_i (dat_w),
        .utx_dat_o (dat_r),
        .utx_ack_o (ack),
        .utx_err_o (err),
        .utx_tx_o  (tx)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: divisor register, bytes awaiting transmission, counts
    logic [15:0] model_div = 16'd433;
    logic [7:0]  exp_q[$];
    int          gap_q[$];
    int          n_pushed = 0;
    int          n_started = 0;
    int          ack_cyc = 0;
    int          start_cyc = 0;

    // Line monitor: each frame must be start, 8 data LSB first, stop, each bit DIV+1 samples
    bit          mon_en = 1'b0;
    bit          mon_active = 1'b0;
    logic [9:0]  wave;
    int          bt;
    int          pos;
    int          idle_cnt = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                mon_active = 1'b0;
                idle_cnt   = 0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_start", {31'b0, tx}, 32'd1);
                    end else begin
                        b    = exp_q.pop_front();
                        wave = {1'b1, b, 1'b0};
                        bt   = int'(model_div) + 1;
                        pos  = 1;
                        mon_active = 1'b1;
                        gap_q.push_back(idle_cnt);
                        idle_cnt  = 0;
                        start_cyc = cyc_cnt;
                        n_started++;
                        if (pos == 10 * bt) mon_active = 1'b0;
                    end
                end else begin
                    idle_cnt++;
                end
            end else begin
                check_eq("tx_bit", {31'b0, tx}, {31'b0, wave[pos / bt]});
                pos++;
                if (pos == 10 * bt) mon_active = 1'b0;
            end
        end
    end

    function automatic logic [31:0] status_exp(input logic bsy);
        int lvl;
        lvl = n_pushed - n_started;
        return {16'h0, 8'(lvl), 5'h0, (lvl == 0), (lvl == 8), bsy};
    endfunction

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic got_ack, output logic got_err);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_w = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack | err) && n < 8);
        got_ack = ack;
        got_err = err;
        rd      = dat_r;
        ack_cyc = cyc_cnt;
        if (!(ack | err)) begin
            check_eq("bus_timeout", {31'b0, ack | err}, 32'd1);
        end else begin
            check_eq("resp_latency", n, 32'd1);
            check_eq("resp_excl", {31'b0, ack & err}, 32'd0);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        check_eq("resp_1cyc", {30'b0, ack, err}, 32'd0);
    endtask

    task automatic wr_data(input logic [7:0] b, input logic [3:0] s);
        logic [31:0] rd;
        logic        a;
        logic        e;
        logic        exp_err;
        exp_err = s[0] && ((n_pushed - n_started) == 8);
        wb_xfer(1'b1, 32'h0, s, {24'h0, b}, rd, a, e);
        check_eq("data_wr_resp", {30'b0, a, e}, exp_err ? 32'd1 : 32'd2);
        check_eq("data_wr_dat", rd, 32'd0);
        if (s[0] && !exp_err) begin
            exp_q.push_back(b);
            n_pushed++;
        end
    endtask

    task automatic wr_div(input logic [15:0] v, input logic [3:0] s);
        logic [31:0] rd;
        logic        a;
        logic        e;
        wb_xfer(1'b1, 32'h8, s, {16'hFFFF, v}, rd, a, e);
        check_eq("div_wr_resp", {30'b0, a, e}, 32'd2);
        if (s[0]) model_div[7:0]  = v[7:0];
        if (s[1]) model_div[15:8] = v[15:8];
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a_in, input logic [31:0] expv);
        logic [31:0] rd;
        logic        a;
        logic        e;
        wb_xfer(1'b0, a_in, 4'hF, 32'h0, rd, a, e);
        check_eq({tag, "_resp"}, {30'b0, a, e}, 32'd2);
        check_eq(tag, rd, expv);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", {31'b0, (exp_q.size() != 0 || mon_active)}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        a;
        logic        e;
        int          g0;
        int          n;
        int          a5_ack;
        logic [7:0]  b;
        logic [3:0]  s;

        // Reset state
        #12;
        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_resp", {30'b0, ack, err}, 32'd0);
        check_eq("rst_dat", dat_r, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        rd_chk("rst_status", 32'h4, status_exp(1'b0));
        rd_chk("rst_div", 32'h8, 32'd433);

        // Single frame 0xA5 at DIV=3 with start-bit latency check
        wr_div(16'd3, 4'b0011);
        wr_data(8'hA5, 4'b0001);
        a5_ack = ack_cyc;
        wait_idle(200);
        check_eq("start_latency", start_cyc - a5_ack, 32'd2);
        rd_chk("idle_status", 32'h4, status_exp(1'b0));

        // Unmapped address, masked DATA write, STATUS write, DATA read
        wb_xfer(1'b0, 32'hC, 4'hF, 32'h0, rd, a, e);
        check_eq("unmap_rd_resp", {30'b0, a, e}, 32'd1);
        check_eq("unmap_rd_dat", rd, 32'd0);
        wb_xfer(1'b1, 32'hC, 4'hF, 32'hFFFF_FFFF, rd, a, e);
        check_eq("unmap_wr_resp", {30'b0, a, e}, 32'd1);
        wr_data(8'h5A, 4'b0010);
        wb_xfer(1'b1, 32'h4, 4'hF, 32'hFFFF_FFFF, rd, a, e);
        check_eq("status_wr_resp", {30'b0, a, e}, 32'd2);
        rd_chk("data_rd", 32'h0, 32'd0);
        rd_chk("noside_status", 32'h4, status_exp(1'b0));
        rd_chk("noside_div", 32'h8, 32'd3);

        // Byte-lane gating on DIV
        wr_div(16'h1234, 4'b0011);
        wr_div(16'hAB99, 4'b0010);
        rd_chk("div_hi_only", 32'h8, {16'h0, model_div});
        wr_div(16'h5507, 4'b0001);
        rd_chk("div_lo_only", 32'h8, {16'h0, model_div});

        // Back-to-back frames at DIV=0 must chain with no idle gap
        wr_div(16'd0, 4'b0011);
        g0 = gap_q.size();
        wr_data(8'h01, 4'b0001);
        wr_data(8'h02, 4'b0001);
        wr_data(8'h03, 4'b0001);
        wait_idle(200);
        check_eq("b2b_frames", gap_q.size() - g0, 32'd3);
        if (gap_q.size() >= g0 + 3) begin
            check_eq("b2b_gap2", gap_q[g0 + 1], 32'd0);
            check_eq("b2b_gap3", gap_q[g0 + 2], 32'd0);
        end

        // DIV change mid-frame applies from the next frame only
        wr_div(16'd3, 4'b0011);
        wr_data(8'h3C, 4'b0001);
        wr_data(8'hC3, 4'b0001);
        n = 0;
        while (!(mon_active && pos > 12) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("midframe_reach", {31'b0, mon_active}, 32'd1);
        wr_div(16'd7, 4'b0011);
        wait_idle(400);
        rd_chk("midframe_div", 32'h8, 32'd7);

        // Fill the FIFO behind a slow frame: 8 accepted, 9th refused
        wr_div(16'd100, 4'b0011);
        wr_data(8'h11, 4'b0001);
        n = 0;
        while (n_started < n_pushed && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("fill_first_start", n_pushed - n_started, 32'd0);
        for (int i = 0; i < 9; i++) begin
            wr_data(8'($urandom), 4'b0001);
            rd_chk("fill_status", 32'h4, status_exp(1'b1));
        end
        wait_idle(12000);
        rd_chk("fill_done_status", 32'h4, status_exp(1'b0));

        // Randomized rounds: random divisor, random bytes and byte selects
        for (int r = 0; r < 8; r++) begin
            wr_div(16'($urandom_range(0, 5)), 4'b0011);
            rd_chk("rnd_div", 32'h8, {16'h0, model_div});
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                s = 4'($urandom_range(0, 15));
                wr_data(b, s);
            end
            wait_idle(2000);
            rd_chk("rnd_status", 32'h4, status_exp(1'b0));
        end

        // Reset mid-frame: line high at once, FIFO discarded, divisor restored
        wr_div(16'd3, 4'b0011);
        wr_data(8'h55, 4'b0001);
        wr_data(8'h66, 4'b0001);
        wr_data(8'h77, 4'b0001);
        n = 0;
        while (!mon_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_mid_reach", {31'b0, mon_active}, 32'd1);
        mon_en = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_mid_low", {31'b0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tx", {31'b0, tx}, 32'd1);
        exp_q.delete();
        n_pushed  = 0;
        n_started = 0;
        model_div = 16'd433;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        rd_chk("rst_mid_status", 32'h4, status_exp(1'b0));
        rd_chk("rst_mid_div", 32'h8, 32'd433);
        repeat (50) @(negedge clk);
        check_eq("rst_mid_quiet", {31'b0, tx}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
